// File: rtl/alu_pkg.sv
// Shared encodings for the iterative RV64M multiply/divide unit.
// Helper functions decode which operands of an op are treated as signed.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic is_div(op_e o);
        return o[2];
    endfunction

    function automatic logic a_signed(op_e o);
        return (o == OP_MUL) || (o == OP_MULH) || (o == OP_MULHSU) ||
               (o == OP_DIV) || (o == OP_REM);
    endfunction

    function automatic logic b_signed(op_e o);
        return (o == OP_MUL) || (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step_64.sv
// One iteration of shift-add multiply or restoring divide over a {hi,lo} pair.
// A single 66-bit adder serves both: add for multiply, subtract for divide.
module muldiv_step_64 (
    input  logic        div,
    input  logic [63:0] hi,
    input  logic [63:0] lo,
    input  logic [63:0] m,
    output logic [63:0] hi_nxt,
    output logic [63:0] lo_nxt
);
    logic [64:0] opa;
    logic [65:0] opb;
    logic [65:0] sum;

    assign opa = div ? {hi, lo[63]} : {1'b0, hi};
    assign opb = div ? ~{2'b00, m} : {2'b00, m};
    assign sum = {1'b0, opa} + opb + {65'd0, div};

    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        if (div) begin
            // sum[65] set means the trial subtraction went negative: restore
            if (!sum[65]) begin
                hi_nxt = sum[63:0];
                lo_nxt = {lo[62:0], 1'b1};
            end else begin
                hi_nxt = opa[63:0];
                lo_nxt = {lo[62:0], 1'b0};
            end
        end else if (lo[0]) begin
            hi_nxt = sum[64:1];
            lo_nxt = {sum[0], lo[63:1]};
        end else begin
            hi_nxt = {1'b0, hi[63:1]};
            lo_nxt = {hi[0], lo[63:1]};
        end
    end
endmodule

// File: rtl/alu_muldiv_64.sv
// Iterative 64-bit RV64M multiply/divide: one setup cycle, 64 CALC iterations,
// one FIX cycle for sign correction, then a single-cycle DONE pulse.
module alu_muldiv_64
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        kill,
    input  logic [2:0]  op,
    input  logic [63:0] A,
    input  logic [63:0] B,
    output logic        busy,
    output logic        done,
    output logic [63:0] X
);
    state_e      state;
    op_e         op_q;
    logic        pend, done_q;
    logic [63:0] a_q, b_q, hi, lo, bm, x_old;
    logic [5:0]  cnt;

    logic        neg_a, neg_b, div_zero, div_ovf;
    logic [63:0] am, bmag, hi_nxt, lo_nxt, special, fixed;
    logic [127:0] prod, prod_s;
    logic [63:0]  quo_s, rem_s;

    assign neg_a    = a_signed(op_q) & a_q[63];
    assign neg_b    = b_signed(op_q) & b_q[63];
    assign am       = neg_a ? -a_q : a_q;
    assign bmag     = neg_b ? -b_q : b_q;
    assign div_zero = is_div(op_q) && (b_q == 64'd0);
    assign div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                      (a_q == 64'h8000_0000_0000_0000) && (b_q == '1);
    assign special  = div_zero ? (((op_q == OP_DIV) || (op_q == OP_DIVU)) ? '1 : a_q)
                               : ((op_q == OP_DIV) ? a_q : 64'd0);

    muldiv_step_64 u_step (
        .div    (is_div(op_q)),
        .hi     (hi),
        .lo     (lo),
        .m      (bm),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    assign prod   = {hi, lo};
    assign prod_s = (neg_a ^ neg_b) ? -prod : prod;
    assign quo_s  = (neg_a ^ neg_b) ? -lo : lo;
    assign rem_s  = neg_a ? -hi : hi;

    always_comb begin
        fixed = rem_s;
        case (op_q)
            OP_MUL:                        fixed = prod_s[63:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fixed = prod_s[127:64];
            OP_DIV, OP_DIVU:               fixed = quo_s;
            default:                       fixed = rem_s;
        endcase
    end

    // kill in DONE drops the pulse in the same cycle; X is restored on the next edge
    assign done = done_q & ~kill;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            op_q   <= OP_MUL;
            pend   <= 1'b0;
            busy   <= 1'b0;
            done_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            hi     <= '0;
            lo     <= '0;
            bm     <= '0;
            cnt    <= '0;
            X      <= '0;
            x_old  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pend) begin
                        pend <= 1'b0;
                        if (kill) begin
                            busy <= 1'b0;
                        end else if (div_zero || div_ovf) begin
                            state  <= S_DONE;
                            busy   <= 1'b0;
                            done_q <= 1'b1;
                            x_old  <= X;
                            X      <= special;
                        end else begin
                            state <= S_CALC;
                            cnt   <= '0;
                            hi    <= '0;
                            lo    <= am;
                            bm    <= bmag;
                        end
                    end else if (start && !kill) begin
                        pend <= 1'b1;
                        busy <= 1'b1;
                        op_q <= op_e'(op);
                        a_q  <= A;
                        b_q  <= B;
                    end
                end
                S_CALC: begin
                    if (kill) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hi  <= hi_nxt;
                        lo  <= lo_nxt;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd63) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= kill ? S_IDLE : S_DONE;
                    busy  <= 1'b0;
                    if (!kill) begin
                        done_q <= 1'b1;
                        x_old  <= X;
                        X      <= fixed;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    if (kill) X <= x_old;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_64.sv
// Self-checking bench for alu_muldiv_64: directed RV64M cases, kill/reset
// behaviour and randomized operations against an arithmetic reference model.
module tb_alu_muldiv_64;
    logic        clk, reset, start, kill, busy, done;
    logic [2:0]  op;
    logic [63:0] A, B, X;
    int          errors = 0;
    int          checks = 0;
    logic [63:0] x_expect = 64'd0;

    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    alu_muldiv_64 dut (
        .clk(clk), .reset(reset), .start(start), .kill(kill), .op(op),
        .A(A), .B(B), .busy(busy), .done(done), .X(X)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb, p;
        logic signed [63:0] sa, sb;
        sa = a;
        sb = b;
        if (o < 3'd4) begin
            ea = (o != 3'd3) ? {{64{a[63]}}, a} : {64'd0, a};
            eb = (o <= 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
            p  = ea * eb;
            return (o == 3'd0) ? p[63:0] : p[127:64];
        end
        if (b == 64'd0) return (o == 3'd4 || o == 3'd5) ? ONES : a;
        if ((o == 3'd4 || o == 3'd6) && a == MINV && b == ONES) return (o == 3'd4) ? a : 64'd0;
        case (o)
            3'd4:    return sa / sb;
            3'd5:    return a / b;
            3'd6:    return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        if (o >= 3'd4 && b == 64'd0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == MINV && b == ONES) return 1;
        return 66;
    endfunction

    // Drives start for exactly the accepting edge (edge 0); returns at the following negedge.
    task automatic start_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int e = 1; e <= 90; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_x, input int exp_lat);
        int lat;
        start_op(o, a, b);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy after accept: got %b want 1", nm, busy);
        end
        wait_done(lat);
        checks++;
        if (lat != exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat);
        end
        checks++;
        if (X !== exp_x) begin
            errors++; $display("FAIL %s X: got %h want %h", nm, X, exp_x);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s busy in done: got %b want 0", nm, busy);
        end
        x_expect = exp_x;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || X !== 64'd0) begin
            errors++; $display("FAIL reset_state: got busy=%b done=%b X=%h want 0 0 0", busy, done, X);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed;
        run_op("mul_7_m3",   3'd0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 66);
        run_op("mulhu_ones", 3'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("mulh_ones",  3'd1, ONES, ONES, 64'd0, 66);
        run_op("div_m7_2",   3'd4, -64'sd7, 64'd2, -64'sd3, 66);
        run_op("rem_m7_2",   3'd6, -64'sd7, 64'd2, ONES, 66);
        run_op("remu_b0",    3'd7, 64'd7, 64'd0, 64'd7, 1);
        run_op("divu_b0",    3'd5, 64'd7, 64'd0, ONES, 1);
        run_op("div_ovf",    3'd4, MINV, ONES, MINV, 1);
        run_op("rem_ovf",    3'd6, MINV, ONES, 64'd0, 1);
        run_op("mulhsu_m1",  3'd2, ONES, 64'd5, ONES, 66);
    endtask

    task automatic test_kill_calc;
        int lat;
        start_op(3'd5, 64'd1000, 64'd7);
        for (int i = 0; i < 31; i++) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || X !== x_expect) begin
            errors++; $display("FAIL kill_calc: got busy=%b done=%b X=%h want 0 0 %h", busy, done, X, x_expect);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL kill_calc_nodone: got %b want 0", done);
        end
        run_op("after_kill", 3'd5, 64'd1000, 64'd7, 64'd142, 66);
        wait_done(lat);
        checks++;
        if (lat != -1) begin
            errors++; $display("FAIL spurious_done: got done at edge %0d want none", lat);
        end
    endtask

    task automatic test_kill_done;
        logic [63:0] prev;
        prev = x_expect;
        start_op(3'd7, 64'd5, 64'd0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || X !== 64'd5) begin
            errors++; $display("FAIL kill_done_pre: got done=%b X=%h want 1 %h", done, X, 64'd5);
        end
        kill = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL kill_done_pulse: got %b want 0", done);
        end
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        checks++;
        if (X !== prev) begin
            errors++; $display("FAIL kill_done_x: got %h want %h", X, prev);
        end
    endtask

    task automatic test_back_to_back;
        run_op("b2b_first", 3'd0, 64'd3, 64'd4, 64'd12, 66);
        start = 1'b1; op = 3'd7; A = 64'd9; B = 64'd0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_ignored: got done=%b busy=%b want 0 0", done, busy);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || X !== 64'd9) begin
            errors++; $display("FAIL b2b_second: got done=%b X=%h want 1 %h", done, X, 64'd9);
        end
        x_expect = 64'd9;
    endtask

    task automatic test_reset_mid;
        int lat;
        @(negedge clk);
        start = 1'b1; op = 3'd4; A = 64'd100; B = 64'd7;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || X !== 64'd0) begin
            errors++; $display("FAIL reset_mid: got busy=%b done=%b X=%h want 0 0 0", busy, done, X);
        end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL reset_restart_accept: got busy=%b want 1", busy);
        end
        wait_done(lat);
        checks++;
        if (lat != 66 || X !== 64'd14) begin
            errors++; $display("FAIL reset_restart_result: got lat=%0d X=%h want 66 %h", lat, X, 64'd14);
        end
        x_expect = 64'd14;
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return ONES;
            2:       return MINV;
            3:       return 64'($urandom_range(0, 300));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic test_random;
        logic [2:0]  o;
        logic [63:0] a, b;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            run_op($sformatf("rand%0d_op%0d", i, o), o, a, b, ref_model(o, a, b), ref_lat(o, a, b));
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_kill_calc;
        test_kill_done;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
